readout_sched: RTL and testbench

Round-robin readout scheduler for the timestamper channels. It watches each channel's `attention` and `overrun` flags and grants one channel at a time. For the granted channel it sequences the shared byte address through one 64-bit FIFO word, pulses that channel's `unload` or `clearoverrun`, and streams the result to the host side as byte packets over a valid/ready handshake. It sits between the channel array and the host bus interface.

---
 rtl/readout_sched.sv | 205 ++++++++++++++++++++
 tb/tb_readout_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_sched.sv
// readout_sched
// Round-robin readout scheduler for the timestamper channel array.
// Grants one channel at a time (searching upward from the last grant),
// walks the shared byte address through that channel's 64-bit FIFO word,
// sends the word to the host as byte packets, then pulses unload (data
// record) or clearoverrun (overrun record) to the granted channel.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   enable         permits new grants; a record in progress always completes
//   attention      per-channel "FIFO not empty or overrun"
//   overrun        per-channel latched overrun flag
//   chan_data      per-channel FIFO byte, channel i at [8i+7:8i]
//   byteaddr       shared byte select driven to all channels
//   unload         one-hot single-cycle FIFO pop
//   clearoverrun   one-hot single-cycle overrun clear
//   out_data       packet byte to host
//   out_valid      out_data valid
//   out_ready      host accepts the byte
//   busy           high in any state other than IDLE
module readout_sched #(
  parameter int NCHAN   = 4,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic [NCHAN-1:0]   attention,
  input  logic [NCHAN-1:0]   overrun,
  input  logic [8*NCHAN-1:0] chan_data,
  output logic [2:0]         byteaddr,
  output logic [NCHAN-1:0]   unload,
  output logic [NCHAN-1:0]   clearoverrun,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int HC_W = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_UNLD = 3'd3,
    S_CLR  = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      gnt_r, gnt_s;
  logic            ovf_r, ovf_s;
  logic [2:0]      last_r, last_s;
  logic [2:0]      byteaddr_r, byteaddr_s;
  logic [HC_W-1:0] hold_r, hold_s;

  logic            found_s;
  logic [2:0]      pick_s;
  logic            pick_ovr_s;
  logic [7:0]      byte_s;

  // Channel index reached by stepping 'step' places above 'base', wrapping at NCHAN.
  function automatic logic [2:0] rr_slot(input logic [2:0] base, input int step);
    int s;
    s = int'(base) + step;
    s = (s >= NCHAN) ? (s - NCHAN) : s;
    return 3'(s);
  endfunction

  // Round-robin search: first requesting channel starting at last+1.
  always_comb begin
    found_s    = 1'b0;
    pick_s     = 3'd0;
    pick_ovr_s = 1'b0;
    for (int k = 1; k <= NCHAN; k++) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (attention[i] && !found_s && (rr_slot(last_r, k) == 3'(i))) begin
          found_s = 1'b1;
          pick_s  = 3'(i);
        end else begin
          found_s = found_s;
        end
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      pick_ovr_s = pick_ovr_s | (overrun[i] & (pick_s == 3'(i)));
    end
  end

  // Byte of the granted channel at the current byte address.
  always_comb begin
    byte_s = 8'h00;
    for (int i = 0; i < NCHAN; i++) begin
      byte_s = byte_s | ({8{gnt_r == 3'(i)}} & chan_data[8*i +: 8]);
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    ovf_s      = ovf_r;
    last_s     = last_r;
    byteaddr_s = byteaddr_r;
    hold_s     = hold_r;
    case (state_r)
      S_IDLE: begin
        if (enable && found_s) begin
          state_s    = S_HDR;
          gnt_s      = pick_s;
          ovf_s      = pick_ovr_s;
          last_s     = pick_s;
          byteaddr_s = 3'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (out_ready) begin
          if (ovf_r) begin
            state_s = S_CLR;
          end else begin
            state_s    = S_DATA;
            byteaddr_s = 3'd0;
          end
        end else begin
          state_s = S_HDR;
        end
      end
      S_DATA: begin
        if (out_ready) begin
          if (byteaddr_r == 3'd7) begin
            state_s    = S_UNLD;
            byteaddr_s = 3'd0;
          end else begin
            byteaddr_s = byteaddr_r + 3'd1;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      S_UNLD: begin
        state_s = S_HOLD;
        hold_s  = '0;
      end
      S_CLR: begin
        state_s = S_HOLD;
        hold_s  = '0;
      end
      S_HOLD: begin
        // Holdoff lets the channel's registered attention catch up with the pop.
        if (hold_r == HC_W'(HOLDOFF - 1)) begin
          state_s = S_IDLE;
          hold_s  = '0;
        end else begin
          hold_s = hold_r + HC_W'(1);
        end
      end
      default: begin
        state_s    = S_IDLE;
        byteaddr_s = 3'd0;
        hold_s     = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any record without a pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= S_IDLE;
      gnt_r      <= 3'd0;
      ovf_r      <= 1'b0;
      last_r     <= 3'(NCHAN - 1);
      byteaddr_r <= 3'd0;
      hold_r     <= '0;
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      ovf_r      <= ovf_s;
      last_r     <= last_s;
      byteaddr_r <= byteaddr_s;
      hold_r     <= hold_s;
    end
  end

  // Output decode straight from the state register.
  always_comb begin
    unload       = '0;
    clearoverrun = '0;
    for (int i = 0; i < NCHAN; i++) begin
      unload[i]       = (state_r == S_UNLD) && (gnt_r == 3'(i));
      clearoverrun[i] = (state_r == S_CLR) && (gnt_r == 3'(i));
    end
    case (state_r)
      S_HDR:   out_data = {ovf_r, 4'b0000, gnt_r};
      S_DATA:  out_data = byte_s;
      default: out_data = 8'h00;
    endcase
    out_valid = (state_r == S_HDR) || (state_r == S_DATA);
    busy      = (state_r != S_IDLE);
    byteaddr  = byteaddr_r;
  end

endmodule

// File: tb/tb_readout_sched.sv
// tb_readout_sched
// Directed bench for readout_sched (NCHAN=4, HOLDOFF=2) with a small
// behavioural channel model: each channel holds one repeating FIFO word,
// a count of words written vs popped, and an overrun set/clear count.
module tb_readout_sched;
  localparam int NCHAN = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b1;
  logic        out_ready = 1'b1;
  logic [3:0]  attention = 4'b0000;
  logic [3:0]  overrun;
  logic [31:0] chan_data;
  logic [2:0]  byteaddr;
  logic [3:0]  unload, clearoverrun;
  logic [7:0]  out_data;
  logic        out_valid, busy;

  readout_sched #(.NCHAN(NCHAN), .HOLDOFF(2)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .attention(attention),
    .overrun(overrun), .chan_data(chan_data), .byteaddr(byteaddr),
    .unload(unload), .clearoverrun(clearoverrun), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // channel model state
  logic [63:0] word_m [NCHAN];
  int wr_cnt_m  [NCHAN];
  int pop_cnt_m [NCHAN];
  int ovs_cnt_m [NCHAN];
  int ovc_cnt_m [NCHAN];

  // channel model: pops/clears on pulses, attention is one clock late
  always @(posedge clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (unload[i]) pop_cnt_m[i] <= pop_cnt_m[i] + 1;
      if (clearoverrun[i]) ovc_cnt_m[i] <= ovc_cnt_m[i] + 1;
      attention[i] <= (wr_cnt_m[i] > pop_cnt_m[i]) || (ovs_cnt_m[i] > ovc_cnt_m[i]);
    end
  end

  // channel model: overrun level and byte mux
  always_comb begin
    overrun   = 4'b0000;
    chan_data = 32'h0;
    for (int i = 0; i < NCHAN; i++) begin
      overrun[i] = ovs_cnt_m[i] > ovc_cnt_m[i];
      chan_data[8*i +: 8] = 8'(word_m[i] >> {byteaddr, 3'b000});
    end
  end

  // host-side monitor
  logic [7:0] byte_q[$];
  logic [7:0] hdr_q[$];
  int pkt_pos = 0;
  int unl_cnt = 0, clr_cnt = 0, busy_cnt = 0, bad_pulse = 0, unl_at_clr = 0;
  logic [3:0] last_unl = 4'b0000, last_clr = 4'b0000;

  // monitor: collect accepted bytes, headers and pulses on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      pkt_pos = 0;
    end else begin
      if (unload != 4'b0000 || clearoverrun != 4'b0000) pkt_pos = 0;
      if (unload != 4'b0000) begin
        unl_cnt++;
        last_unl = unload;
      end
      if (clearoverrun != 4'b0000) begin
        clr_cnt++;
        last_clr = clearoverrun;
        unl_at_clr = unl_cnt;
      end
      if ((unload != 4'b0000 && clearoverrun != 4'b0000) || !$onehot0(unload) || !$onehot0(clearoverrun))
        bad_pulse++;
      if (busy) busy_cnt++;
      if (out_valid && out_ready) begin
        if (pkt_pos == 0) hdr_q.push_back(out_data);
        byte_q.push_back(out_data);
        pkt_pos++;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (busy) quiet = 0;
      else quiet++;
      if (quiet >= 6) return;
    end
    check("wait_idle", 64'(quiet), 64'd6);
  endtask

  task automatic wait_ba(input logic [2:0] val);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (busy && out_valid && byteaddr == val) return;
    end
    check("wait_byteaddr", 64'(byteaddr), 64'(val));
  endtask

  int b0, h0, u0, c0, bc0, p0;
  logic [7:0] exp_rec1 [9] = '{8'h02, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] exp_bp   [9] = '{8'h01, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] exp_rr   [6] = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h01, 8'h03};

  initial begin
    for (int i = 0; i < NCHAN; i++) word_m[i] = 64'h0;
    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_byteaddr", 64'(byteaddr), 64'd0);
    check("rst_unload", 64'(unload), 64'd0);
    check("rst_clearoverrun", 64'(clearoverrun), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rstn = 1'b1;

    // single data record from channel 2
    b0 = byte_q.size(); u0 = unl_cnt; bc0 = busy_cnt;
    word_m[2] = 64'h0123_4567_89AB_CDEF;
    wr_cnt_m[2] = 1;
    wait_idle();
    check("rec_nbytes", 64'(byte_q.size() - b0), 64'd9);
    for (int k = 0; k < 9; k++) check($sformatf("rec_byte%0d", k), 64'(byte_q[b0 + k]), 64'(exp_rec1[k]));
    check("rec_unload_cnt", 64'(unl_cnt - u0), 64'd1);
    check("rec_unload_val", 64'(last_unl), 64'h4);
    check("rec_busy_cycles", 64'(busy_cnt - bc0), 64'd12);
    check("rec_popped", 64'(pop_cnt_m[2]), 64'd1);

    // round robin with attention 1011 held
    do_reset();
    h0 = hdr_q.size();
    word_m[0] = 64'h1010_1010_1010_1010;
    word_m[1] = 64'h2121_2121_2121_2121;
    word_m[3] = 64'h4343_4343_4343_4343;
    wr_cnt_m[0] = 1000; wr_cnt_m[1] = 1000; wr_cnt_m[3] = 1000;
    for (int n = 0; n < 300 && hdr_q.size() < h0 + 6; n++) @(negedge clk);
    for (int i = 0; i < NCHAN; i++) wr_cnt_m[i] = pop_cnt_m[i];
    wait_idle();
    check("rr_enough", 64'(hdr_q.size() >= h0 + 6), 64'd1);
    for (int k = 0; k < 6; k++) check($sformatf("rr_grant%0d", k), 64'(hdr_q[h0 + k]), 64'(exp_rr[k]));

    // backpressure during byte 3
    do_reset();
    b0 = byte_q.size(); u0 = unl_cnt;
    word_m[1] = 64'h1122_3344_5566_7788;
    wr_cnt_m[1] = pop_cnt_m[1] + 1;
    wait_ba(3'd3);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_data", 64'(out_data), 64'h55);
      check("bp_addr", 64'(byteaddr), 64'd3);
      check("bp_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    check("bp_nbytes", 64'(byte_q.size() - b0), 64'd9);
    for (int k = 0; k < 9; k++) check($sformatf("bp_byte%0d", k), 64'(byte_q[b0 + k]), 64'(exp_bp[k]));
    check("bp_unload_cnt", 64'(unl_cnt - u0), 64'd1);

    // overrun on channel 1, data pending behind it
    do_reset();
    b0 = byte_q.size(); h0 = hdr_q.size(); u0 = unl_cnt; c0 = clr_cnt;
    word_m[1] = 64'h0807_0605_0403_0201;
    wr_cnt_m[1] = pop_cnt_m[1] + 1;
    ovs_cnt_m[1] = ovc_cnt_m[1] + 1;
    wait_idle();
    check("ovr_hdr", 64'(hdr_q[h0]), 64'h81);
    check("ovr_next_hdr", 64'(hdr_q[h0 + 1]), 64'h01);
    check("ovr_nbytes", 64'(byte_q.size() - b0), 64'd10);
    check("ovr_clr_cnt", 64'(clr_cnt - c0), 64'd1);
    check("ovr_clr_val", 64'(last_clr), 64'h2);
    check("ovr_no_unload", 64'(unl_at_clr - u0), 64'd0);
    check("ovr_unload_cnt", 64'(unl_cnt - u0), 64'd1);

    // enable dropped during data
    do_reset();
    b0 = byte_q.size(); u0 = unl_cnt;
    word_m[0] = 64'hFEDC_BA98_7654_3210;
    wr_cnt_m[0] = pop_cnt_m[0] + 1000;
    wait_ba(3'd2);
    enable = 1'b0;
    wait_idle();
    bc0 = busy_cnt;
    repeat (20) @(negedge clk);
    check("en_nbytes", 64'(byte_q.size() - b0), 64'd9);
    check("en_unload_cnt", 64'(unl_cnt - u0), 64'd1);
    check("en_no_busy", 64'(busy_cnt - bc0), 64'd0);
    check("en_attention", 64'(attention[0]), 64'd1);
    for (int i = 0; i < NCHAN; i++) wr_cnt_m[i] = pop_cnt_m[i];
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    wait_idle();

    // reset during data at byte 5
    do_reset();
    u0 = unl_cnt;
    p0 = pop_cnt_m[2];
    word_m[2] = 64'hCAFE_F00D_DEAD_BEEF;
    wr_cnt_m[2] = pop_cnt_m[2] + 1;
    wait_ba(3'd5);
    rstn = 1'b0;
    #1;
    check("mid_byteaddr", 64'(byteaddr), 64'd0);
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_out_data", 64'(out_data), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_unload", 64'(unload), 64'd0);
    check("mid_clearoverrun", 64'(clearoverrun), 64'd0);
    word_m[0] = 64'h0F0E_0D0C_0B0A_0908;
    wr_cnt_m[0] = pop_cnt_m[0] + 1;
    h0 = hdr_q.size();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    wait_idle();
    check("mid_first_grant", 64'(hdr_q[h0]), 64'h00);
    check("mid_second_grant", 64'(hdr_q[h0 + 1]), 64'h02);
    check("mid_ch2_pops", 64'(pop_cnt_m[2] - p0), 64'd1);
    check("mid_unload_cnt", 64'(unl_cnt - u0), 64'd2);

    check("pulse_exclusive", 64'(bad_pulse), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
